// File: rtl/snake_pkg.sv
// Shared codes for the snake game control path: direction encodings,
// run-state encodings and the reversal helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } run_state_e;

  // Up/down and left/right share the high bit, so the reverse heading
  // only flips the low bit.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of pending 2-bit headings. Exposes head (next to
// pop) and tail (most recently pushed) so the caller can filter reversals.
// Push and pop in the same cycle are both honoured; the caller guarantees
// it never pushes into a full FIFO without a simultaneous pop.
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    din,
  output logic [1:0]    head,
  output logic [1:0]    tail,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - AW'(1)];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dir_cmd_queue.sv
// Turns keyboard direction/start/reset pulses into one heading update per
// game tick. Holds the IDLE/RUN/PAUSED run state, queues up to DEPTH turns
// and rejects 180-degree reversals against the latest queued heading.
// Build option: define DIR_DEDUP_EN to also reject a turn equal to the
// latest queued heading (stops key auto-repeat from filling the queue).
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               dir_in,
  input  logic                     dir_valid_in,
  input  logic                     start_pause_in,
  input  logic                     reset_evt_in,
  input  logic                     game_tick,
  output logic [1:0]               cur_dir,
  output logic                     move_strobe,
  output logic                     running,
  output logic                     paused,
  output logic                     game_clear,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     drop_pulse
);

  run_state_e state;
  logic       full, empty;
  logic [1:0] head, tail, ref_dir;
  logic       is_run, do_pop, dir_ok, do_push, do_drop;

  assign running = (state == ST_RUN);
  assign paused  = (state == ST_PAUSED);

  // Turn filter: compare against the newest pending heading (pre-pop tail),
  // and let a same-cycle pop make room in a full queue.
  always_comb begin
    is_run  = (state == ST_RUN) && !reset_evt_in;
    ref_dir = empty ? cur_dir : tail;
    do_pop  = is_run && game_tick && !empty;
    dir_ok  = (dir_in != opposite_dir(ref_dir)) && (!full || do_pop);
`ifdef DIR_DEDUP_EN
    dir_ok  = dir_ok && (dir_in != ref_dir);
`else
    dir_ok  = dir_ok;
`endif
    do_push = is_run && dir_valid_in && dir_ok;
    do_drop = is_run && dir_valid_in && !dir_ok;
  end

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (reset_evt_in),
    .push   (do_push),
    .pop    (do_pop),
    .din    (dir_in),
    .head   (head),
    .tail   (tail),
    .full   (full),
    .empty  (empty),
    .count  (q_count)
  );

  // Run-state FSM with registered heading and event pulses; game reset wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cur_dir     <= INIT_DIR;
      move_strobe <= 1'b0;
      drop_pulse  <= 1'b0;
      game_clear  <= 1'b0;
    end else begin
      move_strobe <= is_run && game_tick;
      drop_pulse  <= do_drop;
      game_clear  <= reset_evt_in;
      if (reset_evt_in) begin
        state   <= ST_IDLE;
        cur_dir <= INIT_DIR;
      end else begin
        if (do_pop) cur_dir <= head;
        if (start_pause_in) begin
          case (state)
            ST_IDLE:   state <= ST_RUN;
            ST_RUN:    state <= ST_PAUSED;
            ST_PAUSED: state <= ST_RUN;
            default:   state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Scoreboard bench for dir_cmd_queue: stimulus updates a queue-based
// reference model and pushes expected outputs; a monitor compares each cycle.
module tb_dir_cmd_queue;

  localparam int DEPTH = 4;
  localparam logic [1:0] INIT = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dir_in;
  logic       dir_valid_in, start_pause_in, reset_evt_in, game_tick;
  logic [1:0] cur_dir;
  logic       move_strobe, running, paused, game_clear, drop_pulse;
  logic [2:0] q_count;

  typedef struct {
    logic [1:0] cd;
    logic       ms, run, pau, gc, drop;
    logic [2:0] qc;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state
  int         m_st;        // 0 idle, 1 run, 2 paused
  logic [1:0] m_cd;
  logic [1:0] m_fifo[$];

  dir_cmd_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .dir_valid_in(dir_valid_in),
    .start_pause_in(start_pause_in), .reset_evt_in(reset_evt_in),
    .game_tick(game_tick), .cur_dir(cur_dir), .move_strobe(move_strobe),
    .running(running), .paused(paused), .game_clear(game_clear),
    .q_count(q_count), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    case (d)
      2'b00:   return 2'b01;
      2'b01:   return 2'b00;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.cd = cur_dir; o.ms = move_strobe; o.run = running; o.pau = paused;
    o.gc = game_clear; o.drop = drop_pulse; o.qc = q_count;
    return o;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    n_chk++;
    if (a.cd !== e.cd || a.ms !== e.ms || a.run !== e.run || a.pau !== e.pau ||
        a.gc !== e.gc || a.drop !== e.drop || a.qc !== e.qc) begin
      n_fail++;
      $display("FAIL %s @%0t: got cd=%b ms=%b run=%b pau=%b gc=%b drop=%b qc=%0d, want cd=%b ms=%b run=%b pau=%b gc=%b drop=%b qc=%0d",
               name, $time, a.cd, a.ms, a.run, a.pau, a.gc, a.drop, a.qc,
               e.cd, e.ms, e.run, e.pau, e.gc, e.drop, e.qc);
    end
  endtask

  function automatic obs_t model_reset_obs();
    obs_t o;
    o.cd = INIT; o.ms = 0; o.run = 0; o.pau = 0; o.gc = 0; o.drop = 0; o.qc = 0;
    return o;
  endfunction

  // One cycle of inputs: apply at negedge, advance the model, queue expectation.
  task automatic drive(input logic dv, input logic [1:0] d, input logic sp,
                       input logic re, input logic tk);
    obs_t e;
    logic [1:0] rd;
    bit running_now, pop, accept;
    @(negedge clk);
    dir_valid_in = dv; dir_in = d; start_pause_in = sp;
    reset_evt_in = re; game_tick = tk;
    e = model_reset_obs();
    if (re) begin
      m_st = 0; m_fifo.delete(); m_cd = INIT; e.gc = 1;
    end else begin
      running_now = (m_st == 1);
      pop = running_now && tk && (m_fifo.size() > 0);
      accept = 0;
      if (running_now && dv) begin
        rd = (m_fifo.size() > 0) ? m_fifo[m_fifo.size()-1] : m_cd;
        accept = 1;
        if (d == reverse_of(rd)) accept = 0;
        if (m_fifo.size() == DEPTH && !pop) accept = 0;
`ifdef DIR_DEDUP_EN
        if (d == rd) accept = 0;
`endif
        e.drop = !accept;
      end
      if (pop) m_cd = m_fifo.pop_front();
      if (accept) m_fifo.push_back(d);
      e.ms = running_now && tk;
      if (sp) m_st = (m_st == 1) ? 2 : 1;
    end
    e.cd = m_cd; e.qc = 3'(m_fifo.size());
    e.run = (m_st == 1); e.pau = (m_st == 2);
    exp_q.push_back(e);
  endtask

  task automatic idle(); drive(0, 2'b00, 0, 0, 0); endtask

  // Monitor: every cycle with a pending expectation, compare just after the edge.
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) check("cycle", cur_obs(), exp_q.pop_front());
  end

  initial begin
    reset_n = 0; dir_in = 0; dir_valid_in = 0; start_pause_in = 0;
    reset_evt_in = 0; game_tick = 0;
    m_st = 0; m_cd = INIT;
    repeat (3) @(posedge clk);
    #1 check("reset_state", cur_obs(), model_reset_obs());
    @(negedge clk); reset_n = 1;

    // Start, turn up, tick
    drive(0, 2'b00, 1, 0, 0);
    drive(1, 2'b00, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1);
    idle();
    // Get back to right, then attempt reversal to left
    drive(1, 2'b11, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(1, 2'b10, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1);
    // Fill and overflow, then drain
    drive(1, 2'b00, 0, 0, 0);
    drive(1, 2'b10, 0, 0, 0);
    drive(1, 2'b01, 0, 0, 0);
    drive(1, 2'b11, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0);
    repeat (4) drive(0, 2'b00, 0, 0, 1);
    // Refill, then push + tick while full
    drive(1, 2'b00, 0, 0, 0);
    drive(1, 2'b10, 0, 0, 0);
    drive(1, 2'b01, 0, 0, 0);
    drive(1, 2'b11, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 1);
    // Pause; dir and tick ignored; resume
    drive(0, 2'b00, 1, 0, 0);
    drive(1, 2'b10, 0, 0, 1);
    drive(0, 2'b00, 1, 0, 0);
    // Game reset together with start and dir
    drive(1, 2'b00, 1, 1, 1);
    idle();
    // Restart, push same direction twice
    drive(0, 2'b00, 1, 0, 0);
    drive(1, 2'b00, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0);
    idle();

    // Randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        dir_valid_in = 0; start_pause_in = 0; reset_evt_in = 0; game_tick = 0;
        #2 reset_n = 0;
        #1 check("async_reset", cur_obs(), model_reset_obs());
        m_st = 0; m_cd = INIT; m_fifo.delete();
        @(negedge clk); reset_n = 1;
      end
      drive($urandom_range(0, 9) < 4, 2'($urandom), $urandom_range(0, 29) == 0,
            $urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
